// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead add/subtract sequencer.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Index width for a nibble counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carryadder.sv
// 4-bit carry-lookahead adder slice: all carries derived from generate/propagate in one level.
module carryadder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o  = p ^ c[3:0];
    cout_o = c[4];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract sequencer: walks wide operands one nibble per cycle through
// a single shared carryadder slice, chaining the carry through a register.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      op_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = idx_width(NIBBLES);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;     // B already inverted on subtract
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last_nibble;

  always_comb begin
    slice_a     = a_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];
    slice_b     = b_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];
    last_nibble = (idx_q == IdxW'(NIBBLES - 1));
  end

  carryadder u_carryadder (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {W{op_sub}};
          carry_d = op_sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[32'(idx_q) * NIBBLE_W +: NIBBLE_W] = slice_sum;
        carry_d = slice_cout;
        if (last_nibble) begin
          cout_d  = slice_cout;
          // Like-signed operands producing an opposite-signed result.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-precision add/subtract sequencer built around a single 4-bit carry-lookahead adder slice (`carryadder`). It accepts a `NIBBLES*4`-bit operand pair over a valid/ready handshake. It walks the operands one nibble per cycle through the shared adder, chaining the carry through a register, then presents sum, carry-out and signed overflow on an output valid/ready handshake. It sits between the datapath register file and any wide-arithmetic consumer, trading latency for a single 4-bit adder instance.

## Interface
- `NIBBLES`, 4: operand width in nibbles; total width `W = 4*NIBBLES`; legal range 1..16.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair and `op_sub` valid.
- `in_ready`  out  1  block can accept a new operation.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `op_sub`  in  1  0: A+B; 1: A−B, computed as A+~B+1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  W  result, modulo 2^W.
- `cout`  out  1  carry out of the MSB nibble. On subtract, 1 means no borrow.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `a`, `b ^ {W{op_sub}}`, `op_sub`.
  - Set carry register = `op_sub` and nibble index = 0, then go to RUN.
- RUN, `in_ready`=0:
  - Each cycle, drive nibble `idx` of A and B' plus the carry register into `carryadder`.
  - Write the slice sum into nibble `idx` of the result register and the slice cout into the carry register.
  - Increment `idx`.
  - After the cycle that processes `idx = NIBBLES−1`, go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum`, `cout`, `ovf` are held stable until `out_valid & out_ready`, then go to IDLE.
- Overflow: `ovf = (A[W−1] == B'[W−1]) & (sum[W−1] != A[W−1])`, using B' (the inverted B on subtract).
- Inputs are ignored outside IDLE. `a`/`b` changing during RUN has no effect.
- `out_ready` is ignored outside DONE.
- `idx` width is `clog2(NIBBLES)`, minimum 1 bit. `idx` never exceeds `NIBBLES−1`, so there is no wrap.
- `NIBBLES=1`: RUN lasts exactly one cycle.

## Timing
- Reset, asynchronous, any state, including mid-RUN:
  - State=IDLE, `in_ready`=1, `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0; idx=0; carry register=0.
  - Any in-flight operation is discarded.
- Let the accepting edge be E0. Nibble k is computed in the cycle after edge E0+k and registered at edge E0+k+1.
- `out_valid` rises after edge E0+NIBBLES. Latency is NIBBLES+1 cycles from acceptance to the first cycle `out_valid` is visible.
- `out_valid` stays high with stable data while `out_ready`=0.
- `in_ready` rises in the cycle after the output handshake edge. Minimum issue interval is NIBBLES+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `in_ready` is a decode of the state register only.

## Structure
- Shared package `cla_pkg`:
  - State enum (IDLE/RUN/DONE).
  - `NIBBLE_W = 4`.
  - A `clog2`-style index-width function.
- One sub-module: the existing `carryadder`, instantiated once and reused unmodified. All sequencing, carry chaining and result assembly live in `cla_seq_adder`.

## Test plan
- Reset, then NIBBLES=4, add A=0x1234, B=0x1111 -> sum=0x2345, cout=0, ovf=0. `out_valid` is first seen 5 cycles after acceptance.
- Carry ripple across all nibbles: A=0xFFFF + B=0x0001 -> sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - A=0x7FFF + B=0x0001 -> sum=0x8000, ovf=1, cout=0.
  - Subtract A=0x8000 − B=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Subtract with borrow: A=0x0003 − B=0x0005 -> sum=0xFFFE, cout=0, ovf=0. Hold `out_ready`=0 for 3 cycles; `sum` is stable and `in_ready`=0 throughout.
- `rst_n` asserted mid-RUN (after 2 nibbles) -> all outputs 0 and `in_ready`=1 immediately. The next operation, 0x0F0F+0x0101=0x1010, is unaffected by the aborted operation.
- NIBBLES=1: 0x9+0x8 -> sum=0x1, cout=1, ovf=1. Then back-to-back issue with `in_valid` held high: the second operation is accepted exactly NIBBLES+2=3 cycles after the first.
